// File: rtl/tft_pattern_gen.sv
`default_nettype none
// ============================================================================
// tft_pattern_gen : parametrised RGB565 test-pattern source for the TFT path
// Rev 1.0
// ============================================================================
module tft_pattern_gen #(
  parameter int H_ACT       = 800,
  parameter int V_ACT       = 480,
  parameter int COLS        = 2,
  parameter int ROWS        = 4,
  parameter int CELL_LOG2   = 5,
  parameter int RAMP_SHIFT  = 5,
  parameter int SCROLL_STEP = 4,
  parameter int BLINK_LOG2  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hs_cnt_i,
  input  logic [11:0] vs_cnt_i,
  input  logic        de_i,
  input  logic [1:0]  mode_sel_i,
  output logic [15:0] pix_data_o,
  output logic        pix_de_o,
  output logic [15:0] frame_cnt_o,
  output logic [1:0]  mode_act_o
);

  localparam int c_BAND_W  = H_ACT / COLS;
  localparam int c_BAND_H  = V_ACT / ROWS;
  localparam int c_SUB_W   = (c_BAND_W > 1) ? $clog2(c_BAND_W) : 1;
  localparam int c_RSUB_W  = (c_BAND_H > 1) ? $clog2(c_BAND_H) : 1;
  localparam int c_COL_W   = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [c_SUB_W-1:0]  c_SUB_MAX   = c_SUB_W'(c_BAND_W - 1);
  localparam logic [c_RSUB_W-1:0] c_RSUB_MAX  = c_RSUB_W'(c_BAND_H - 1);
  localparam logic [c_COL_W-1:0]  c_COL_MAX   = c_COL_W'(COLS - 1);
  localparam logic [c_SUB_W:0]    c_BAND_W_X  = (c_SUB_W + 1)'(c_BAND_W);
  localparam logic [c_SUB_W:0]    c_STEP_X    = (c_SUB_W + 1)'(SCROLL_STEP);
  localparam logic [2:0]          c_COLS_MOD8 = 3'(COLS % 8);

  function automatic logic [c_COL_W-1:0] f_next_col(input logic [c_COL_W-1:0] col);
    return (col == c_COL_MAX) ? '0 : col + c_COL_W'(1);
  endfunction

  function automatic logic [15:0] f_palette(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'h0000;
      3'd1:    return 16'h001F;
      3'd2:    return 16'hF800;
      3'd3:    return 16'hF81F;
      3'd4:    return 16'h07E0;
      3'd5:    return 16'h07FF;
      3'd6:    return 16'hFFE0;
      default: return 16'hFFFF;
    endcase
  endfunction

  logic                w_line_start, w_frame_start;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [1:0]          mode_act_q, mode_act_d;
  logic [c_COL_W-1:0]  col_q, col_d, frm_col_q, frm_col_d, start_col_q, start_col_d;
  logic [c_SUB_W-1:0]  sub_q, sub_d, frm_sub_q, frm_sub_d, start_sub_q, start_sub_d;
  logic [c_RSUB_W-1:0] rsub_q, rsub_d;
  logic [2:0]          rbase_q, rbase_d;
  logic [c_COL_W-1:0]  w_cur_col;
  logic [c_SUB_W-1:0]  w_cur_sub;
  logic [2:0]          w_cur_rbase;
  logic [c_SUB_W:0]    w_start_sum;
  logic [11:0]         w_ramp;

  logic                s1_de_q, s1_de_d, s1_par_q, s1_par_d;
  logic [1:0]          s1_mode_q, s1_mode_d;
  logic [2:0]          s1_pal_q, s1_pal_d;
  logic [4:0]          s1_lvl_q, s1_lvl_d;
  logic [15:0]         pix_data_q, pix_data_d;
  logic                pix_de_q, pix_de_d;
  logic [15:0]         w_colour;

  assign w_line_start  = de_i && (hs_cnt_i == 12'd0);
  assign w_frame_start = w_line_start && (vs_cnt_i == 12'd0);
  assign w_start_sum   = {1'b0, start_sub_q} + c_STEP_X;

  // Band tracking: w_cur_* is the band of the pixel on the inputs this cycle.
  // frm_* holds the scroll offset used by every line of the current frame,
  // while start_* already points at the offset for the next mode-3 frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    mode_act_d  = mode_act_q;
    frm_col_d   = frm_col_q;
    frm_sub_d   = frm_sub_q;
    start_col_d = start_col_q;
    start_sub_d = start_sub_q;
    rsub_d      = rsub_q;
    rbase_d     = rbase_q;
    w_cur_col   = col_q;
    w_cur_sub   = sub_q;
    w_cur_rbase = rbase_q;
    if (w_frame_start) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      mode_act_d  = mode_sel_i;
      rsub_d      = '0;
      rbase_d     = '0;
      w_cur_rbase = '0;
      if (mode_sel_i == 2'd3) begin
        frm_col_d = start_col_q;
        frm_sub_d = start_sub_q;
        if (w_start_sum >= c_BAND_W_X) begin
          start_sub_d = c_SUB_W'(w_start_sum - c_BAND_W_X);
          start_col_d = f_next_col(start_col_q);
        end else begin
          start_sub_d = w_start_sum[c_SUB_W-1:0];
        end
      end else begin
        frm_col_d = '0;
        frm_sub_d = '0;
      end
      w_cur_col = frm_col_d;
      w_cur_sub = frm_sub_d;
    end else if (w_line_start) begin
      if (rsub_q == c_RSUB_MAX) begin
        rsub_d  = '0;
        rbase_d = rbase_q + c_COLS_MOD8;
      end else begin
        rsub_d  = rsub_q + c_RSUB_W'(1);
      end
      w_cur_col   = frm_col_q;
      w_cur_sub   = frm_sub_q;
      w_cur_rbase = rbase_d;
    end

    col_d = col_q;
    sub_d = sub_q;
    if (de_i) begin
      if (w_cur_sub == c_SUB_MAX) begin
        sub_d = '0;
        col_d = f_next_col(w_cur_col);
      end else begin
        sub_d = w_cur_sub + c_SUB_W'(1);
        col_d = w_cur_col;
      end
    end
  end

  assign w_ramp = hs_cnt_i >> RAMP_SHIFT;

  // Stage 1: band index, checker parity and ramp level per pixel.
  always_comb begin
    s1_de_d   = de_i;
    s1_mode_d = mode_act_d;
    s1_pal_d  = w_cur_rbase + 3'(w_cur_col);
    s1_par_d  = hs_cnt_i[CELL_LOG2] ^ vs_cnt_i[CELL_LOG2] ^ frame_cnt_d[BLINK_LOG2];
    s1_lvl_d  = (w_ramp > 12'd31) ? 5'd31 : w_ramp[4:0];
  end

  // Stage 2: colour, blanked outside the active area.
  always_comb begin
    w_colour = 16'h0000;
    case (s1_mode_q)
      2'd1:    w_colour = s1_par_q ? 16'h0000 : 16'hFFFF;
      2'd2:    w_colour = {s1_lvl_q, s1_lvl_q, 1'b0, s1_lvl_q};
      default: w_colour = f_palette(s1_pal_q);
    endcase
    pix_data_d = s1_de_q ? w_colour : 16'h0000;
    pix_de_d   = s1_de_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      mode_act_q  <= '0;
      col_q       <= '0;
      sub_q       <= '0;
      frm_col_q   <= '0;
      frm_sub_q   <= '0;
      start_col_q <= '0;
      start_sub_q <= '0;
      rsub_q      <= '0;
      rbase_q     <= '0;
      s1_de_q     <= 1'b0;
      s1_mode_q   <= '0;
      s1_pal_q    <= '0;
      s1_par_q    <= 1'b0;
      s1_lvl_q    <= '0;
      pix_data_q  <= '0;
      pix_de_q    <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      mode_act_q  <= mode_act_d;
      col_q       <= col_d;
      sub_q       <= sub_d;
      frm_col_q   <= frm_col_d;
      frm_sub_q   <= frm_sub_d;
      start_col_q <= start_col_d;
      start_sub_q <= start_sub_d;
      rsub_q      <= rsub_d;
      rbase_q     <= rbase_d;
      s1_de_q     <= s1_de_d;
      s1_mode_q   <= s1_mode_d;
      s1_pal_q    <= s1_pal_d;
      s1_par_q    <= s1_par_d;
      s1_lvl_q    <= s1_lvl_d;
      pix_data_q  <= pix_data_d;
      pix_de_q    <= pix_de_d;
    end
  end

  assign pix_data_o  = pix_data_q;
  assign pix_de_o    = pix_de_q;
  assign frame_cnt_o = frame_cnt_q;
  assign mode_act_o  = mode_act_q;

endmodule
`default_nettype wire

// File: tb/tb_tft_pattern_gen.sv
`default_nettype none
// ============================================================================
// tb_tft_pattern_gen : scoreboard bench for tft_pattern_gen (800x480 defaults)
// Rev 1.0
// ============================================================================
module tb_tft_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hs, vs;
  logic        de;
  logic [1:0]  mode_sel;
  logic [15:0] pix_data, frame_cnt;
  logic        pix_de;
  logic [1:0]  mode_act;

  tft_pattern_gen dut (
    .clk         (clk),
    .rst         (rst),
    .hs_cnt_i    (hs),
    .vs_cnt_i    (vs),
    .de_i        (de),
    .mode_sel_i  (mode_sel),
    .pix_data_o  (pix_data),
    .pix_de_o    (pix_de),
    .frame_cnt_o (frame_cnt),
    .mode_act_o  (mode_act)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;   // 1: pixel/de, 2: frame_cnt/mode_act
    int          x;
    int          y;
    logic        exp_de;
    logic [15:0] exp_data;
    logic [15:0] exp_fc;
    logic [1:0]  exp_mode;
  } chk_t;

  chk_t        sb[$];
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  int          pts_x[$];
  int          pts_y[$];
  logic [15:0] pts_e[$];
  int          st_line = -1;
  logic [15:0] st_fc   = 16'd0;
  logic [1:0]  st_mode = 2'd0;

  always @(posedge clk) cyc++;

  // Monitor: compares whatever entries fall due on this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        total++;
        if (sb[i].kind == 1) begin
          if (pix_de !== sb[i].exp_de || pix_data !== sb[i].exp_data) begin
            bad++;
            $display("FAIL %s(%0d,%0d): got de=%b data=%h, want de=%b data=%h",
                     (sb[i].x < 0) ? "blank" : "pix", sb[i].x, sb[i].y,
                     pix_de, pix_data, sb[i].exp_de, sb[i].exp_data);
          end
        end else begin
          if (frame_cnt !== sb[i].exp_fc || mode_act !== sb[i].exp_mode) begin
            bad++;
            $display("FAIL state@y%0d: got frame_cnt=%0d mode_act=%0d, want frame_cnt=%0d mode_act=%0d",
                     sb[i].y, frame_cnt, mode_act, sb[i].exp_fc, sb[i].exp_mode);
          end
        end
        sb.delete(i);
      end
    end
  end

  task automatic drive(input int x, input int y, input logic d, input logic r);
    @(negedge clk);
    rst = r;
    hs  = 12'(x);
    vs  = 12'(y);
    de  = d;
  endtask

  task automatic expect_pix(input int x, input int y, input logic d, input logic [15:0] e,
                            input int lat);
    chk_t c;
    c.due = cyc + lat; c.kind = 1; c.x = x; c.y = y;
    c.exp_de = d; c.exp_data = e; c.exp_fc = 16'd0; c.exp_mode = 2'd0;
    sb.push_back(c);
  endtask

  task automatic expect_state(input int y, input logic [15:0] fc, input logic [1:0] m);
    chk_t c;
    c.due = cyc + 1; c.kind = 2; c.x = 0; c.y = y;
    c.exp_de = 1'b0; c.exp_data = 16'h0; c.exp_fc = fc; c.exp_mode = m;
    sb.push_back(c);
  endtask

  task automatic clear_pts();
    pts_x.delete(); pts_y.delete(); pts_e.delete();
  endtask

  task automatic pt(input int x, input int y, input logic [15:0] e);
    pts_x.push_back(x); pts_y.push_back(y); pts_e.push_back(e);
  endtask

  task automatic pixel(input int x, input int y);
    drive(x, y, 1'b1, 1'b0);
    if (x == 0 && (y == 0 || y == st_line)) expect_state(y, st_fc, st_mode);
    for (int i = 0; i < pts_x.size(); i++)
      if (pts_x[i] == x && pts_y[i] == y) expect_pix(x, y, 1'b1, pts_e[i], 2);
  endtask

  // hs parked at 799 while blanked so an ungated ramp would show up.
  task automatic blank(input int y, input logic chk);
    drive(799, y, 1'b0, 1'b0);
    if (chk) expect_pix(-1, y, 1'b0, 16'h0000, 2);
  endtask

  task automatic full_line(input int y);
    for (int x = 0; x < 800; x++) pixel(x, y);
    blank(y, 1'b1);
    blank(y, 1'b0);
  endtask

  task automatic short_line(input int y);
    pixel(0, y);
    blank(y, 1'b0);
  endtask

  task automatic frame(input logic [1:0] m, input int last, input int fa, input int fb,
                       input int fcl, input int sw_line, input logic [1:0] sw_mode,
                       input logic [15:0] exp_fc);
    st_fc    = exp_fc;
    st_mode  = m;
    st_line  = sw_line;
    mode_sel = m;
    for (int y = 0; y <= last; y++) begin
      if (y == sw_line) mode_sel = sw_mode;
      if (y == fa || y == fb || y == fcl) full_line(y);
      else short_line(y);
    end
  endtask

  initial begin
    rst = 1'b1; hs = '0; vs = '0; de = 1'b0; mode_sel = 2'd0;
    drive(0, 0, 1'b0, 1'b1);
    drive(0, 0, 1'b1, 1'b1);
    expect_pix(-1, 0, 1'b0, 16'h0000, 1);
    expect_state(0, 16'd0, 2'd0);
    drive(799, 0, 1'b0, 1'b0);
    drive(799, 0, 1'b0, 1'b0);

    // Frame 1: colour bars
    clear_pts();
    pt(0, 0, 16'h0000);   pt(399, 0, 16'h0000);   pt(400, 0, 16'h001F);   pt(799, 0, 16'h001F);
    pt(0, 120, 16'hF800); pt(399, 120, 16'hF800); pt(400, 120, 16'hF81F);
    pt(0, 479, 16'hFFE0); pt(799, 479, 16'hFFFF);
    frame(2'd0, 479, 0, 120, 479, -1, 2'd0, 16'd1);

    // Frame 2: checker, frame_cnt[5]=0
    clear_pts();
    pt(0, 0, 16'hFFFF); pt(31, 0, 16'hFFFF); pt(32, 0, 16'h0000); pt(64, 0, 16'hFFFF);
    pt(0, 32, 16'h0000); pt(32, 32, 16'hFFFF);
    frame(2'd1, 32, 0, 32, -1, -1, 2'd0, 16'd2);

    // Frame 3: gray ramp
    clear_pts();
    pt(0, 0, 16'h0000); pt(31, 0, 16'h0000); pt(32, 0, 16'h0841);
    pt(400, 0, 16'h630C); pt(799, 0, 16'hC618);
    frame(2'd2, 0, 0, -1, -1, -1, 2'd0, 16'd3);

    // Frame 4: first scroll frame, offset 0
    clear_pts();
    pt(0, 0, 16'h0000);   pt(399, 0, 16'h0000);   pt(400, 0, 16'h001F);   pt(799, 0, 16'h001F);
    pt(0, 120, 16'hF800); pt(400, 120, 16'hF81F);
    pt(0, 479, 16'hFFE0); pt(799, 479, 16'hFFFF);
    frame(2'd3, 479, 0, 120, 479, -1, 2'd0, 16'd4);

    // Frame 5: second scroll frame, offset 4
    clear_pts();
    pt(0, 0, 16'h0000);   pt(395, 0, 16'h0000); pt(396, 0, 16'h001F);
    pt(795, 0, 16'h001F); pt(796, 0, 16'h0000); pt(799, 0, 16'h0000);
    frame(2'd3, 0, 0, -1, -1, -1, 2'd0, 16'd5);

    // Frames 6..32: short checker frames (scroll offset must hold)
    clear_pts();
    for (int f = 6; f <= 32; f++) frame(2'd1, 0, -1, -1, -1, -1, 2'd0, 16'(f));

    // Frame 33: checker phase inverted
    clear_pts();
    pt(0, 0, 16'h0000); pt(32, 0, 16'hFFFF); pt(0, 32, 16'hFFFF); pt(32, 32, 16'h0000);
    frame(2'd1, 32, 0, 32, -1, -1, 2'd0, 16'd33);

    // Frames 34..231: scroll frames 3..200
    clear_pts();
    for (int f = 34; f <= 231; f++) frame(2'd3, 0, -1, -1, -1, -1, 2'd0, 16'(f));

    // Frame 232: scroll frame 201, offset back to 0
    clear_pts();
    pt(0, 0, 16'h0000); pt(396, 0, 16'h0000); pt(399, 0, 16'h0000);
    pt(400, 0, 16'h001F); pt(799, 0, 16'h001F);
    frame(2'd3, 0, 0, -1, -1, -1, 2'd0, 16'd232);

    // Frame 233: mode_sel moves to ramp at line 100, frame stays bars
    clear_pts();
    pt(0, 100, 16'h0000); pt(400, 100, 16'h001F); pt(799, 100, 16'h001F);
    frame(2'd0, 100, 100, -1, -1, 100, 2'd2, 16'd233);

    // Frame 234: ramp takes effect
    clear_pts();
    pt(32, 0, 16'h0841); pt(400, 0, 16'h630C);
    frame(2'd2, 0, 0, -1, -1, -1, 2'd0, 16'd234);

    // Frame 235: scroll frame, reset pulse at (500,300)
    clear_pts();
    frame(2'd3, 299, -1, -1, -1, -1, 2'd0, 16'd235);
    for (int x = 0; x < 500; x++) pixel(x, 300);
    drive(500, 300, 1'b1, 1'b1);
    expect_pix(500, 300, 1'b0, 16'h0000, 1);
    expect_state(300, 16'd0, 2'd0);
    expect_pix(500, 300, 1'b0, 16'h0000, 2);
    for (int x = 501; x < 800; x++) pixel(x, 300);
    blank(300, 1'b0);

    // First frame after reset: frame_cnt=1, scroll offset 0
    clear_pts();
    pt(0, 0, 16'h0000); pt(392, 0, 16'h0000); pt(399, 0, 16'h0000); pt(400, 0, 16'h001F);
    frame(2'd3, 0, 0, -1, -1, -1, 2'd0, 16'd1);

    for (int i = 0; i < 4; i++) blank(0, 1'b0);
    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL pending(%0d,%0d): got no sample, want one due at cycle %0d",
               sb[0].x, sb[0].y, sb[0].due);
      sb.delete(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
